// File: rtl/csa_ft_pkg.sv
// Shared constants, types and helper functions for the fault-tolerant carry-select
// adder BIST and reconfiguration slice.
package csa_ft_pkg;

    localparam int NUM_UNITS = 6;
    localparam int NUM_OBS   = 5;
    localparam int NUM_SLOTS = 4;
    localparam int NUM_VEC   = 16;
    localparam int CSC_W     = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_CHECK,
        ST_MAP,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [2:0] is0;
        logic [2:0] is1;
        logic [3:0] ss0;
        logic [3:0] ss1;
    } cfg_t;

    // u[j] is the physical unit serving logical slot j.
    typedef logic [NUM_SLOTS-1:0][2:0] slot_map_t;

    // Test-mode response of one 2-bit carry-select unit for vector {x1,y1,x0,y0}.
    function automatic logic [CSC_W-1:0] csc_golden(input logic [3:0] vec);
        logic [1:0] x;
        logic [1:0] y;
        logic [1:0] c1;
        logic [1:0] c0;
        logic [1:0] s1;
        logic [1:0] s0;
        logic       k0;
        logic       k1;
        x = {vec[3], vec[1]};
        y = {vec[2], vec[0]};
        for (int i = 0; i < 2; i++) begin
            c1[i] = x[i] ^ y[i];
            c0[i] = (x[i] & y[i]) ^ ~(x[i] ^ y[i]);
            s1[i] = ~(x[i] ^ y[i]);
            s0[i] = x[i] ^ y[i];
        end
        k0 = c0[0];
        k1 = c1[0];
        return {k1 ? c1[1] : c0[1],
                k0 ? c1[1] : c0[1],
                k1 ? s1[1] : s0[1],
                s1[0],
                k0 ? s1[1] : s0[1],
                s0[0]};
    endfunction

    // Offsets never decrease from slot to slot, so counting the slots shifted by at
    // least one (is0) and by two (is1) fully describes the input steering.
    function automatic logic [5:0] in_sel(input slot_map_t u);
        logic [2:0] n1;
        logic [2:0] n2;
        logic [2:0] d;
        n1 = '0;
        n2 = '0;
        for (int j = 0; j < NUM_SLOTS; j++) begin
            d  = u[j] - 3'(j);
            n1 = n1 + {2'b00, (d != 3'd0)};
            n2 = n2 + {2'b00, (d == 3'd2)};
        end
        return {n2, n1};
    endfunction

endpackage

// File: rtl/csa_bist_reconfig_ctrl_if.sv
// Handshake and datapath-facing signals of the BIST/reconfiguration controller.
interface csa_bist_reconfig_ctrl_if;
    import csa_ft_pkg::*;

    logic                     start;
    logic [NUM_OBS*CSC_W-1:0] actual_output;
    logic                     test;
    logic [3:0]               test_data;
    logic [2:0]               is0;
    logic [2:0]               is1;
    logic [3:0]               ss0;
    logic [3:0]               ss1;
    logic                     busy;
    logic                     done;
    logic                     cfg_valid;
    logic                     fatal;
    logic [NUM_OBS-1:0]       fault_mask;

    modport master (
        input  start, actual_output,
        output test, test_data, is0, is1, ss0, ss1,
               busy, done, cfg_valid, fatal, fault_mask
    );

    modport slave (
        output start, actual_output,
        input  test, test_data, is0, is1, ss0, ss1,
               busy, done, cfg_valid, fatal, fault_mask
    );

endinterface

// File: rtl/csa_cfg_map.sv
// Combinational map from the sticky fault mask to the slot steering configuration;
// unit 5 is the untested spare and always counts as healthy.
module csa_cfg_map
    import csa_ft_pkg::*;
(
    input  logic [NUM_OBS-1:0] fault_mask,
    output cfg_t               cfg,
    output logic               too_many
);

    logic [NUM_UNITS-1:0]      healthy;
    slot_map_t                 u;
    logic [NUM_SLOTS-1:0][2:0] d;

    assign healthy  = {1'b1, ~fault_mask};
    assign too_many = ($countones(fault_mask) > 2);

    // Each slot takes the lowest healthy unit above the one chosen for the previous slot.
    always_comb begin
        int   nxt;
        logic found;
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        u     = '0;
        nxt   = 0;
        found = 1'b0;
        for (int j = 0; j < NUM_SLOTS; j++) begin
            found = 1'b0;
            for (int k = 0; k < NUM_UNITS; k++) begin
                if (!found && k >= nxt && healthy[k]) begin
                    u[j]  = 3'(k);
                    nxt   = k + 1;
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_SLOTS; j++) begin
            d[j] = u[j] - 3'(j);
        end
    end

    always_comb begin
        cfg              = '0;
        {cfg.is1, cfg.is0} = in_sel(u);
        cfg.ss0[0]       = (d[0] == 3'd1);
        for (int k = 1; k < NUM_SLOTS; k++) begin
            cfg.ss0[k] = (d[k] == 3'd1) || (d[k-1] == 3'd2);
        end
        for (int k = 0; k < NUM_SLOTS; k++) begin
            cfg.ss1[k] = (d[k] == 3'd2);
        end
    end

endmodule

// File: rtl/csa_bist_reconfig_ctrl.sv
// Sweeps all test vectors through the adder in test mode, accumulates a sticky fault
// mask and commits a steering configuration that routes around up to two bad units.
module csa_bist_reconfig_ctrl
    import csa_ft_pkg::*;
#(
    parameter int SETTLE_CYC = 1
) (
    input logic                      clk,
    input logic                      rst,
    csa_bist_reconfig_ctrl_if.master bus
);

    state_t             state;
    logic [2:0]         wait_cnt;
    logic [3:0]         vec;
    logic               test_q;
    cfg_t               cfg_q;
    logic               busy_q;
    logic               done_q;
    logic               cfg_valid_q;
    logic               fatal_q;
    logic [NUM_OBS-1:0] fault_mask_q;

    cfg_t               cfg_next;
    logic               too_many;
    logic [CSC_W-1:0]   golden;
    logic [NUM_OBS-1:0] miscompare;

    csa_cfg_map u_cfg_map (
        .fault_mask (fault_mask_q),
        .cfg        (cfg_next),
        .too_many   (too_many)
    );

    assign golden = csc_golden(vec);

    always_comb begin
        for (int k = 0; k < NUM_OBS; k++) begin
            miscompare[k] = (bus.actual_output[CSC_W*k +: CSC_W] != golden);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            vec          <= '0;
            test_q       <= 1'b0;
            cfg_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_valid_q  <= 1'b1;
            fatal_q      <= 1'b0;
            fault_mask_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state        <= ST_DRIVE;
                        vec          <= '0;
                        wait_cnt     <= '0;
                        test_q       <= 1'b1;
                        busy_q       <= 1'b1;
                        fault_mask_q <= '0;
                        fatal_q      <= 1'b0;
                        cfg_valid_q  <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (wait_cnt == 3'(SETTLE_CYC - 1)) begin
                        state <= ST_CHECK;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                ST_CHECK: begin
                    fault_mask_q <= fault_mask_q | miscompare;
                    if (vec == 4'(NUM_VEC - 1)) begin
                        state  <= ST_MAP;
                        test_q <= 1'b0;
                    end else begin
                        state    <= ST_DRIVE;
                        vec      <= vec + 4'd1;
                        wait_cnt <= '0;
                    end
                end
                ST_MAP: begin
                    // A failed map leaves the previously committed selects in place.
                    if (too_many) begin
                        fatal_q <= 1'b1;
                    end else begin
                        cfg_q       <= cfg_next;
                        cfg_valid_q <= 1'b1;
                    end
                    done_q <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.test       = test_q;
    assign bus.test_data  = vec;
    assign bus.is0        = cfg_q.is0;
    assign bus.is1        = cfg_q.is1;
    assign bus.ss0        = cfg_q.ss0;
    assign bus.ss1        = cfg_q.ss1;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.cfg_valid  = cfg_valid_q;
    assign bus.fatal      = fatal_q;
    assign bus.fault_mask = fault_mask_q;

endmodule
